imem_stream_loader: RTL

//  Writer side of the instruction memory: replaces the bench-only $readmemh backdoor with a synthesizable

---
 rtl/imem_stream_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/imem_stream_loader.sv
// Byte-stream imem loader: length-prefixed little-endian words into imem,
// holding the core in reset until the image is complete.
module imem_stream_loader #(
  parameter int ADDR_W     = 8,
  parameter int IMEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, FLUSH, DONE, ERR
  } state_t;

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  lane;
  logic [23:0] partial;
  logic        accept;
  logic [15:0] len_in;

  assign accept = s_valid && s_ready;
  assign len_in = {s_data, len_lo};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s_ready      <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset   <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      len_lo       <= '0;
      len          <= '0;
      lane         <= '0;
      partial      <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LEN_LO;
            s_ready      <= 1'b1;
            words_loaded <= '0;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len_lo <= s_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len          <= len_in;
            lane         <= '0;
            words_loaded <= '0;
            if (len_in == 16'd0) begin
              state      <= DONE;
              s_ready    <= 1'b0;
              load_done  <= 1'b1;
              core_reset <= 1'b0;
            end else if (len_in > 16'(IMEM_WORDS)) begin
              state    <= ERR;
              s_ready  <= 1'b0;
              load_err <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              // last lane completes the word; write it next cycle
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= {s_data, partial};
              words_loaded <= words_loaded + 16'd1;
              if (words_loaded == len - 16'd1) begin
                state   <= FLUSH;
                s_ready <= 1'b0;
              end
            end else begin
              partial[8*lane +: 8] <= s_data;
            end
          end
        end
        FLUSH: begin
          state      <= DONE;
          load_done  <= 1'b1;
          core_reset <= 1'b0;
        end
        DONE, ERR: begin
          if (start) begin
            state        <= LEN_LO;
            s_ready      <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            core_reset   <= 1'b1;
            words_loaded <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
